fb_pixel_writer: RTL

- Drawing engine that writes pixels into the packed 2-bit-per-pixel framebuffer that the video scanout reads.
- Accepts PLOT, XOR-PLOT and horizontal-span-fill commands over a valid/ready handshake.
- Performs read-modify-write on 16-bit framebuffer words through an arbitrated RAM port shared with the CPU and video.
- Sits between the CPU command registers and the RAM arbiter.

---
 rtl/fb_pixel_writer_if.sv | 33 +++
 rtl/fb_pixel_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: command and RAM-port bundle for the framebuffer pixel writer.
//   cmd_*      : command handshake from the CPU command registers
//   mem_*      : arbitrated RAM word port (request/grant, read data one cycle after grant)
//   busy/done  : engine status
// Modport slave is the engine's view; modport master is the view of whatever drives
// commands and answers RAM requests.
interface fb_pixel_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_x_end;
  logic [7:0]  cmd_y;
  logic [1:0]  cmd_color;
  logic        mem_req;
  logic        mem_grant;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_x_end, cmd_y, cmd_color, mem_grant, mem_rdata,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_x_end, cmd_y, cmd_color, mem_grant, mem_rdata,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: drawing engine for the packed 2-bit-per-pixel framebuffer.
// Executes PLOT, XOR-PLOT and horizontal span fills as read-modify-write of
// 16-bit words over a shared, arbitrated RAM port. Fully covered span words are
// written without a read.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : asynchronous active-low reset
//   bus   : fb_pixel_writer_if.slave (command handshake, RAM port, busy/done)
module fb_pixel_writer #(
  parameter logic [14:0] FB_BASE         = 15'h4000,
  parameter int unsigned LINE_WORDS_LOG2 = 5
) (
  input logic              clk,
  input logic              reset,
  fb_pixel_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_XOR   = 2'd1;
  localparam logic [1:0] OP_HSPAN = 2'd2;

  // Ones over the slots of word 'word' that fall inside [x_lo, x_hi]. Slot 0 is the MSB pair.
  function automatic logic [15:0] f_word_mask(input logic [4:0] word,
                                               input logic [7:0] x_lo,
                                               input logic [7:0] x_hi);
    logic [2:0]  s_lo;
    logic [2:0]  s_hi;
    logic [15:0] m;
    s_lo = (word == x_lo[7:3]) ? x_lo[2:0] : 3'd0;
    s_hi = (word == x_hi[7:3]) ? x_hi[2:0] : 3'd7;
    m    = 16'h0000;
    for (int s = 0; s < 8; s++) begin
      m[15-2*s -: 2] = ((3'(s) >= s_lo) && (3'(s) <= s_hi)) ? 2'b11 : 2'b00;
    end
    return m;
  endfunction

  // RAM word index of word 'word' on row 'y'.
  function automatic logic [14:0] f_addr(input logic [7:0] y, input logic [4:0] word);
    return FB_BASE + (15'(y) << LINE_WORDS_LOG2) + 15'(word);
  endfunction

  state_t      r_state;
  logic [4:0]  r_word;
  logic        r_is_xor;
  logic [7:0]  r_x_lo;
  logic [7:0]  r_x_hi;
  logic [7:0]  r_y;
  logic [1:0]  r_color;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [14:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [4:0]  w_word_nxt;
  logic [14:0] w_addr_nxt;
  logic [15:0] w_wdata_nxt;
  logic        w_accept;
  logic        w_acc_span;
  logic        w_acc_empty;
  logic [7:0]  w_acc_hi;
  logic [15:0] w_acc_mask;
  logic [15:0] w_cur_mask;
  logic [4:0]  w_next_word;
  logic [15:0] w_next_mask;
  logic [15:0] w_pattern;

  // A PLOT is a span of one pixel, so the hi bound collapses to x for non-span ops.
  assign w_accept    = bus.cmd_valid && (r_state == S_IDLE);
  assign w_acc_span  = (bus.cmd_op == OP_HSPAN);
  assign w_acc_hi    = w_acc_span ? bus.cmd_x_end : bus.cmd_x;
  assign w_acc_empty = w_acc_span && (bus.cmd_x_end < bus.cmd_x);
  assign w_acc_mask  = f_word_mask(bus.cmd_x[7:3], bus.cmd_x, w_acc_hi);
  assign w_cur_mask  = f_word_mask(r_word, r_x_lo, r_x_hi);
  assign w_next_word = r_word + 5'd1;
  assign w_next_mask = f_word_mask(w_next_word, r_x_lo, r_x_hi);
  assign w_pattern   = {8{r_color}};

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Next-state, next-word and next write-data decode of the command sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_word_nxt = bus.cmd_x[7:3];
          w_addr_nxt = f_addr(bus.cmd_y, bus.cmd_x[7:3]);
          if (w_acc_empty) begin
            w_state_nxt = S_DONE;
          end else if (w_acc_span && (w_acc_mask == 16'hFFFF)) begin
            w_state_nxt = S_WR;
            w_wdata_nxt = {8{bus.cmd_color}};
          end else begin
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (bus.mem_grant) begin
          w_state_nxt = S_RDW;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_RDW: begin
        if (r_is_xor) begin
          w_wdata_nxt = bus.mem_rdata ^ (w_pattern & w_cur_mask);
        end else begin
          w_wdata_nxt = (bus.mem_rdata & ~w_cur_mask) | (w_pattern & w_cur_mask);
        end
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (bus.mem_grant) begin
          if (r_word != r_x_hi[7:3]) begin
            w_word_nxt = w_next_word;
            w_addr_nxt = f_addr(r_y, w_next_word);
            if (w_next_mask == 16'hFFFF) begin
              w_state_nxt = S_WR;
              w_wdata_nxt = w_pattern;
            end else begin
              w_state_nxt = S_RD;
            end
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_WR;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus bus outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_word      <= 5'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 15'd0;
      r_mem_wdata <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= w_word_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_req   <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      r_mem_we    <= (w_state_nxt == S_WR);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Command fields captured on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_xor <= 1'b0;
      r_x_lo   <= 8'd0;
      r_x_hi   <= 8'd0;
      r_y      <= 8'd0;
      r_color  <= 2'd0;
    end else if (w_accept) begin
      r_is_xor <= (bus.cmd_op == OP_XOR);
      r_x_lo   <= bus.cmd_x;
      r_x_hi   <= w_acc_hi;
      r_y      <= bus.cmd_y;
      r_color  <= bus.cmd_color;
    end else begin
      r_is_xor <= r_is_xor;
      r_x_lo   <= r_x_lo;
      r_x_hi   <= r_x_hi;
      r_y      <= r_y;
      r_color  <= r_color;
    end
  end

endmodule
